uart_tx_cfg: RTL and testbench
==============================

Name: uart_tx_cfg

Overview:
- Parametrised UART transmitter, successor to the fixed 8N1 transmitter.
- Configurable data width, parity mode and stop-bit count.
- Valid/ready byte intake, synchronous reset and exact per-bit timing.
- Sits between the host command path (byte source) and the board TX pin; pairs with the existing UART receiver.

Parameters:
- CYCLES_PER_BIT, 10400: clock cycles per serial bit; legal range 2..65535.
- DATA_BITS, 8: payload bits per frame; legal range 5..9.
- PARITY, 0: 0 = none, 1 = odd, 2 = even; any other value is illegal and fails elaboration.
- STOP_BITS, 1: stop bits per frame; 1 or 2.

Ports:
- clk  input  1  system clock; all logic is rising-edge.
- rst  input  1  reset, synchronous, active-high.
- in  input  DATA_BITS  payload; sent LSB first.
- in_valid  input  1  payload present.
- in_ready  output  1  block can accept a payload; high only in IDLE.
- tx  output  1  serial line, idle high.
- busy  output  1  high in every non-IDLE state.
- done  output  1  one-cycle pulse when a frame completes.

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset values, registered on the clk edge where rst=1:
  - state=IDLE, tx=1, done=0, busy=0, bit counter=0, cycle counter=0.
  - in_ready=1 from the following cycle.
  - in_valid is ignored in any cycle where rst=1.
- Accept: a transfer occurs on a clk edge with in_valid=1 and in_ready=1.
  - in is latched into the shift register on that edge.
  - Later changes on in do not affect the frame.
- States: IDLE -> START -> DATA -> (PARITY if PARITY!=0) -> STOP -> IDLE.
- Timing:
  - If the accept is at edge N, tx=0 from cycle N+1.
  - Every bit, including start, parity and each stop bit, is held on tx for exactly CYCLES_PER_BIT cycles.
  - No bit may be short or long by one cycle.
- DATA: bit i = in[i] for i = 0..DATA_BITS-1, LSB first. The bit index counter wraps only on the transition out of DATA.
- PARITY bit:
  - odd mode: XOR of the latched data, inverted.
  - even mode: XOR of the latched data.
  - Computed from the latched copy, not from the live input.
- STOP: tx=1 for STOP_BITS*CYCLES_PER_BIT cycles.
- Completion: on the edge ending the last stop cycle, state goes to IDLE and done=1 for exactly one cycle. in_ready=1 in that same cycle.
- Back-to-back: if in_valid=1 during the done cycle, the next byte is accepted there. The line shows exactly one idle-high cycle between frames.
- Frame length, accept to done: 1 + (1 + DATA_BITS + (PARITY!=0) + STOP_BITS) * CYCLES_PER_BIT cycles.
- in_valid in non-IDLE states: ignored; in_ready=0.
- Reset mid-frame: abort on the next edge. tx=1 immediately and no done pulse; the partial frame is lost.
- Widths:
  - Cycle counter is $clog2(CYCLES_PER_BIT) bits; it compares against CYCLES_PER_BIT-1 and returns to 0.
  - Bit index is $clog2(DATA_BITS+1) bits.
- tx is driven from a register, never combinationally.

Decomposition:
- uart_pkg holds:
  - the state enum typedef (IDLE, START, DATA, PARITY, STOP);
  - parity mode constants PAR_NONE/PAR_ODD/PAR_EVEN;
  - a helper function for frame length in cycles, shared with the receiver bench.
- Sub-module uart_bit_timer:
  - parameter CYCLES_PER_BIT; inputs clk, rst, clear;
  - output tick, a one-cycle pulse at the last cycle of each bit period;
  - the FSM uses tick to advance.

Test Plan (bench uses CYCLES_PER_BIT=4 unless noted):
- 8N1, send 0xA5: tx sequence per 4-cycle slot is 0,1,0,1,0,0,1,0,1,1. done asserts 41 cycles after accept.
- DATA_BITS=7, PARITY=2 (even), STOP_BITS=2, send 0x55: data bits 1,0,1,0,1,0,1, parity 0, two stop slots. Frame length 1+11*4=45 cycles.
- PARITY=1 (odd), send 0x00: parity bit is 1. Then send 0xFF: parity bit is 1.
- Back-to-back: in_valid held high with 0x3C then 0xC3. The second start bit begins 2 cycles after the first done edge (one idle-high cycle). Each byte is accepted exactly once.
- Reset mid-frame: assert rst for 1 cycle during data bit 3. tx=1 on the next cycle, no done, in_ready=1. A subsequent 0x81 frame is correct.
- in toggled every cycle after accept: the transmitted bits equal the value latched at accept. in_ready=0 throughout the frame, and extra in_valid pulses are not accepted.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg
// Shared definitions for the configurable UART transmitter and its receiver bench.
// Contents:
//   uart_state_t   transmitter FSM state encoding
//   PAR_*          parity mode constants (PARITY parameter values)
//   frame_cycles() accept-to-done length of one frame in clock cycles
//   parity_bit()   parity line value from the XOR of the payload bits
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    // The leading 1 is the cycle between the accept edge and the start bit
    // appearing on the line.
    function automatic int unsigned frame_cycles(
        input int unsigned cycles_per_bit,
        input int unsigned data_bits,
        input int unsigned parity,
        input int unsigned stop_bits
    );
        int unsigned n_slots;
        n_slots = 1 + data_bits + ((parity != 0) ? 1 : 0) + stop_bits;
        return 1 + n_slots * cycles_per_bit;
    endfunction

    function automatic logic parity_bit(input int parity, input logic data_xor);
        return (parity == PAR_ODD) ? ~data_xor : data_xor;
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// uart_bit_timer
// Bit-period timer. Counts 0 .. CYCLES_PER_BIT-1 and wraps; tick marks the
// last cycle of each bit period so the FSM can advance on the following edge.
// Ports:
//   clk    system clock
//   rst    synchronous active-high reset
//   clear  holds the count at 0 (idle and the lead cycle of a frame)
//   tick   one-cycle pulse in the last cycle of a bit period
module uart_bit_timer #(
    parameter int CYCLES_PER_BIT = 10400
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int             CW   = $clog2(CYCLES_PER_BIT);
    localparam logic [CW-1:0]  LAST = CW'(CYCLES_PER_BIT - 1);

    logic [CW-1:0] r_cnt;
    logic          w_at_last;

    assign w_at_last = (r_cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_cnt <= '0;
        end else if (w_at_last) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign tick = w_at_last && !clear;

endmodule

// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg
// Parametrised UART transmitter: DATA_BITS payload, optional odd/even parity,
// one or two stop bits, every bit held for exactly CYCLES_PER_BIT cycles.
// Ports:
//   clk       system clock, rising edge
//   rst       synchronous active-high reset; aborts any frame in progress
//   in        payload, sent LSB first, latched on accept
//   in_valid  payload present
//   in_ready  high only in IDLE; accept = in_valid & in_ready on a clk edge
//   tx        registered serial line, idle high
//   busy      high in every non-IDLE state
//   done      one-cycle pulse as the frame completes (coincides with in_ready)
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_IDLE   | line high, waiting for a payload
// ST_START  | one lead cycle (line still high), then the start bit
// ST_DATA   | payload bits LSB first
// ST_PARITY | parity bit (only when PARITY != PAR_NONE)
// ST_STOP   | STOP_BITS stop bits, then done pulse and back to idle
module uart_tx_cfg
    import uart_pkg::*;
#(
    parameter int CYCLES_PER_BIT = 10400,
    parameter int DATA_BITS      = 8,
    parameter int PARITY         = 0,
    parameter int STOP_BITS      = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] in,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic                 tx,
    output logic                 busy,
    output logic                 done
);

    if (CYCLES_PER_BIT < 2 || CYCLES_PER_BIT > 65535) begin : g_bad_cpb
        $error("uart_tx_cfg: CYCLES_PER_BIT must be 2..65535");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_tx_cfg: DATA_BITS must be 5..9");
    end
    if (PARITY != PAR_NONE && PARITY != PAR_ODD && PARITY != PAR_EVEN) begin : g_bad_parity
        $error("uart_tx_cfg: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
        $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
    end

    localparam int             BW       = $clog2(DATA_BITS + 1);
    localparam logic [BW-1:0]  LAST_BIT = BW'(DATA_BITS - 1);
    localparam logic           HAS_PAR  = (PARITY != PAR_NONE);

    uart_state_t          r_state;
    uart_state_t          w_state_nxt;
    logic [DATA_BITS-1:0] r_shift;
    logic [BW-1:0]        r_bit_idx;
    logic                 r_stop_idx;
    logic                 r_lead;
    logic                 r_par;
    logic                 r_tx;
    logic                 r_done;
    logic                 w_tx_nxt;
    logic                 w_done_nxt;
    logic                 w_tick;
    logic                 w_timer_clear;
    logic                 w_accept;
    logic                 w_last_bit;
    logic                 w_last_stop;

    assign w_accept      = in_valid && (r_state == ST_IDLE);
    assign w_last_bit    = (r_bit_idx == LAST_BIT);
    assign w_last_stop   = (STOP_BITS == 1) ? 1'b1 : r_stop_idx;
    // The timer stays at 0 through the lead cycle so the start bit gets a
    // full CYCLES_PER_BIT once the line actually drops.
    assign w_timer_clear = (r_state == ST_IDLE) || r_lead;

    uart_bit_timer #(
        .CYCLES_PER_BIT (CYCLES_PER_BIT)
    ) u_bit_timer (
        .clk   (clk),
        .rst   (rst),
        .clear (w_timer_clear),
        .tick  (w_tick)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = ST_START;
                end
            end
            ST_START: begin
                if (w_tick) begin
                    w_state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_tick && w_last_bit) begin
                    w_state_nxt = HAS_PAR ? ST_PARITY : ST_STOP;
                end
            end
            ST_PARITY: begin
                if (w_tick) begin
                    w_state_nxt = ST_STOP;
                end
            end
            ST_STOP: begin
                if (w_tick && w_last_stop) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Output logic: the value the line takes from the next edge onward.
    // Changing tx on the same edge as the state keeps each slot exactly one
    // bit period long.
    always_comb begin
        w_tx_nxt   = r_tx;
        w_done_nxt = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_tx_nxt = 1'b1;
            end
            ST_START: begin
                if (r_lead) begin
                    w_tx_nxt = 1'b0;
                end else if (w_tick) begin
                    w_tx_nxt = r_shift[0];
                end
            end
            ST_DATA: begin
                if (w_tick) begin
                    if (w_last_bit) begin
                        w_tx_nxt = HAS_PAR ? r_par : 1'b1;
                    end else begin
                        // r_shift moves down on this same edge
                        w_tx_nxt = r_shift[1];
                    end
                end
            end
            ST_PARITY: begin
                if (w_tick) begin
                    w_tx_nxt = 1'b1;
                end
            end
            ST_STOP: begin
                w_tx_nxt = 1'b1;
                if (w_tick && w_last_stop) begin
                    w_done_nxt = 1'b1;
                end
            end
            default: w_tx_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx   <= 1'b1;
            r_done <= 1'b0;
        end else begin
            r_tx   <= w_tx_nxt;
            r_done <= w_done_nxt;
        end
    end

    // Payload, counters and parity
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift    <= '0;
            r_bit_idx  <= '0;
            r_stop_idx <= 1'b0;
            r_lead     <= 1'b0;
            r_par      <= 1'b0;
        end else begin
            r_lead <= w_accept;

            if (w_accept) begin
                r_shift <= in;
            end else if (r_state == ST_DATA && w_tick) begin
                r_shift <= r_shift >> 1;
            end

            // Parity taken from the latched payload before any shifting.
            if (r_state == ST_START && w_tick) begin
                r_par <= parity_bit(PARITY, ^r_shift);
            end

            if (r_state == ST_DATA && w_tick) begin
                r_bit_idx <= w_last_bit ? '0 : r_bit_idx + BW'(1);
            end

            if (r_state == ST_STOP && w_tick) begin
                r_stop_idx <= w_last_stop ? 1'b0 : 1'b1;
            end
        end
    end

    assign tx       = r_tx;
    assign done     = r_done;
    assign busy     = (r_state != ST_IDLE);
    assign in_ready = (r_state == ST_IDLE);

endmodule

// File: tb/tb_uart_tx_cfg.sv
// tb_uart_tx_cfg
// Directed bench for uart_tx_cfg at CYCLES_PER_BIT=4 with three instances:
// 8N1 (sel 0), 7E2 (sel 1) and 8O1 (sel 2). Expected line slots are
// hand-computed constants, bit k of 'bits' being slot k (slot 0 = start).
module tb_uart_tx_cfg;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] vld;
    logic [7:0] in0;
    logic [6:0] in1;
    logic [7:0] in2;
    wire  [2:0] rdy_w;
    wire  [2:0] tx_w;
    wire  [2:0] busy_w;
    wire  [2:0] done_w;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    uart_tx_cfg #(.CYCLES_PER_BIT(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
        .clk(clk), .rst(rst), .in(in0), .in_valid(vld[0]), .in_ready(rdy_w[0]),
        .tx(tx_w[0]), .busy(busy_w[0]), .done(done_w[0]));

    uart_tx_cfg #(.CYCLES_PER_BIT(4), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) u_7e2 (
        .clk(clk), .rst(rst), .in(in1), .in_valid(vld[1]), .in_ready(rdy_w[1]),
        .tx(tx_w[1]), .busy(busy_w[1]), .done(done_w[1]));

    uart_tx_cfg #(.CYCLES_PER_BIT(4), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_8o1 (
        .clk(clk), .rst(rst), .in(in2), .in_valid(vld[2]), .in_ready(rdy_w[2]),
        .tx(tx_w[2]), .busy(busy_w[2]), .done(done_w[2]));

    typedef struct {
        int          sel;
        logic [8:0]  data;
        logic [15:0] bits;
        int          nslots;
        int          len;
        bit          toggle;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic set_in(input int sel, input logic [8:0] v);
        case (sel)
            0: in0 = v[7:0];
            1: in1 = v[6:0];
            default: in2 = v[7:0];
        endcase
    endtask

    // Called at the negedge right after the accept edge (j = 0). Returns at
    // the negedge where done is seen (or after the cycle budget).
    task automatic capture(input int sel, input logic [15:0] bits, input int nslots,
                           input int len, input bit toggle, input logic [8:0] data);
        int         done_at   = -1;
        bit         ready_bad = 1'b0;
        bit         busy_bad  = 1'b0;
        logic [8:0] cur       = data;
        for (int j = 0; j < len + 20; j++) begin
            if (done_w[sel]) begin
                done_at = j;
                if (toggle) vld[sel] = 1'b0;
                break;
            end
            if (j == 0) begin
                check($sformatf("lead_tx sel%0d", sel), int'(tx_w[sel]), 1);
            end else begin
                int slot;
                slot = (j - 1) / 4;
                if (slot < nslots)
                    check($sformatf("tx sel%0d j%0d", sel, j), int'(tx_w[sel]),
                          int'(bits[4'(slot)]));
                if (rdy_w[sel])   ready_bad = 1'b1;
                if (!busy_w[sel]) busy_bad  = 1'b1;
            end
            if (toggle) begin
                cur = ~cur;
                set_in(sel, cur);
                vld[sel] = ((j % 3) == 0);
            end
            @(negedge clk);
        end
        check($sformatf("done_latency sel%0d", sel), done_at, len);
        check($sformatf("ready_low_in_frame sel%0d", sel), int'(ready_bad), 0);
        check($sformatf("busy_high_in_frame sel%0d", sel), int'(busy_bad), 0);
        if (done_at >= 0) begin
            check($sformatf("ready_in_done_cycle sel%0d", sel), int'(rdy_w[sel]), 1);
            check($sformatf("tx_in_done_cycle sel%0d", sel), int'(tx_w[sel]), 1);
        end
    endtask

    task automatic run_frame(input vec_t v);
        @(negedge clk);
        set_in(v.sel, v.data);
        check($sformatf("ready_before sel%0d", v.sel), int'(rdy_w[v.sel]), 1);
        vld[v.sel] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if (!v.toggle) vld[v.sel] = 1'b0;
        capture(v.sel, v.bits, v.nslots, v.len, v.toggle, v.data);
        @(negedge clk);
        check($sformatf("done_one_cycle sel%0d", v.sel), int'(done_w[v.sel]), 0);
        check($sformatf("no_reaccept sel%0d", v.sel), int'(busy_w[v.sel]), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit   saw_done;
        vec_t v81;

        vecs[0] = '{0, 9'h0A5, 16'b1101001010,  10, 41, 1'b0};
        vecs[1] = '{1, 9'h055, 16'b11010101010, 11, 45, 1'b0};
        vecs[2] = '{2, 9'h000, 16'b11000000000, 11, 45, 1'b0};
        vecs[3] = '{2, 9'h0FF, 16'b11111111110, 11, 45, 1'b0};
        vecs[4] = '{0, 9'h05A, 16'b1010110100,  10, 41, 1'b1};
        v81     = '{0, 9'h081, 16'b1100000010,  10, 41, 1'b0};

        rst = 1'b1;
        vld = 3'b111;   // must be ignored while rst is high
        in0 = 8'h00;
        in1 = 7'h00;
        in2 = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        vld = 3'b000;
        rst = 1'b0;
        for (int s = 0; s < 3; s++) begin
            check($sformatf("rst_tx sel%0d", s),    int'(tx_w[s]),   1);
            check($sformatf("rst_busy sel%0d", s),  int'(busy_w[s]), 0);
            check($sformatf("rst_done sel%0d", s),  int'(done_w[s]), 0);
            check($sformatf("rst_ready sel%0d", s), int'(rdy_w[s]),  1);
        end

        for (int i = 0; i < 5; i++) run_frame(vecs[i]);

        // Back-to-back with in_valid held high: 0x3C then 0xC3
        @(negedge clk);
        in0    = 8'h3C;
        vld[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in0 = 8'hC3;
        capture(0, 16'b1001111000, 10, 41, 1'b0, 9'h03C);
        @(negedge clk);
        check("b2b_idle_gap_tx", int'(tx_w[0]),   1);
        check("b2b_second_accept", int'(busy_w[0]), 1);
        check("b2b_done_pulse_width", int'(done_w[0]), 0);
        vld[0] = 1'b0;
        capture(0, 16'b1110000110, 10, 41, 1'b0, 9'h0C3);
        @(negedge clk);
        check("b2b_accepted_once", int'(busy_w[0]), 0);

        // Reset during data bit 3 of 0xF0
        @(negedge clk);
        in0    = 8'hF0;
        vld[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        vld[0] = 1'b0;
        repeat (18) @(negedge clk);
        check("pre_reset_bit3", int'(tx_w[0]), 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_tx",    int'(tx_w[0]),   1);
        check("abort_busy",  int'(busy_w[0]), 0);
        check("abort_ready", int'(rdy_w[0]),  1);
        check("abort_done",  int'(done_w[0]), 0);
        saw_done = 1'b0;
        repeat (50) begin
            @(negedge clk);
            if (done_w[0]) saw_done = 1'b1;
        end
        check("abort_no_done", int'(saw_done), 0);

        run_frame(v81);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
